// File: rtl/branch_target_predictor_pkg.sv
// Purpose: shared types, counter encodings and saturating-update helper for the branch target predictor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_target_predictor_pkg;

    typedef logic [1:0] ctr_t;

    // Direction counter encodings: strongly/weakly not-taken, weakly/strongly taken.
    localparam ctr_t CTR_SNT = 2'd0;
    localparam ctr_t CTR_WNT = 2'd1;
    localparam ctr_t CTR_WT  = 2'd2;
    localparam ctr_t CTR_ST  = 2'd3;

    // Move the counter one step towards the resolved direction, saturating at both ends.
    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        if (taken) begin
            nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// Purpose: 2-bit saturating direction counter next-state logic.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module sat_counter2
    import branch_target_predictor_pkg::*;
(
    input  logic [1:0] ctr_cur,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    // Next counter value for a conditional branch resolving in direction taken.
    always_comb begin
        ctr_nxt = sat_update(ctr_cur, taken);
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Purpose: direct-mapped BTB with per-entry 2-bit direction counters, plus branch/mispredict counters.
// Latency: lookup combinational (zero cycles); updates visible the cycle after the resolving edge.
// Backpressure: none; lookup always answers, EX updates are accepted every cycle they are presented.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int width   = 32,
    parameter int entries = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] fetch_pc,
    output logic             predict_taken,
    output logic [width-1:0] predict_target,
    input  logic             ex_valid,
    input  logic [width-1:0] ex_pc,
    input  logic             ex_taken,
    input  logic [width-1:0] ex_target,
    input  logic             ex_uncond,
    input  logic             ex_mispredict,
    output logic [31:0]      branch_count,
    output logic [31:0]      mispredict_count
);

    localparam int idx_bits = $clog2(entries);
    localparam int tag_bits = width - idx_bits - 2;

    typedef struct packed {
        logic                valid;
        logic [tag_bits-1:0] tag;
        logic [width-1:0]    target;
        ctr_t                ctr;
    } btb_entry_t;

    // Flop array so every valid bit can be cleared in the reset cycle.
    btb_entry_t btb_q [entries];

    logic [idx_bits-1:0] fetch_idx;
    logic [tag_bits-1:0] fetch_tag;
    logic [idx_bits-1:0] ex_idx;
    logic [tag_bits-1:0] ex_tag;
    btb_entry_t          fetch_ent;
    btb_entry_t          ex_ent;
    logic                fetch_hit;
    logic                ex_hit;
    ctr_t                ex_ctr_nxt;

    // Byte-offset bits carry no information for 4-byte-aligned instructions.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], ex_pc[1:0]};

    assign fetch_idx = fetch_pc[idx_bits+1:2];
    assign fetch_tag = fetch_pc[width-1:idx_bits+2];
    assign ex_idx    = ex_pc[idx_bits+1:2];
    assign ex_tag    = ex_pc[width-1:idx_bits+2];

    // Lookup reads the registered entry, so a same-cycle update is not bypassed.
    always_comb begin
        fetch_ent      = btb_q[fetch_idx];
        fetch_hit      = fetch_ent.valid && (fetch_ent.tag == fetch_tag);
        predict_taken  = fetch_hit && fetch_ent.ctr[1];
        // Forced to zero on a miss so uninitialised targets never leak out.
        predict_target = fetch_hit ? fetch_ent.target : '0;
    end

    // Resolve-side hit detection for the entry addressed by ex_pc.
    always_comb begin
        ex_ent = btb_q[ex_idx];
        ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);
    end

    sat_counter2 u_sat_counter2 (
        .ctr_cur (ex_ent.ctr),
        .taken   (ex_taken),
        .ctr_nxt (ex_ctr_nxt)
    );

    // Entry training/allocation and performance counters; reset wins over any update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < entries; i++) begin
                btb_q[i].valid <= 1'b0;
            end
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (ex_valid) begin
            branch_count <= branch_count + 32'd1;
            if (ex_mispredict) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
            if (ex_hit) begin
                if (ex_uncond) begin
                    btb_q[ex_idx].ctr    <= CTR_ST;
                    btb_q[ex_idx].target <= ex_target;
                end else begin
                    btb_q[ex_idx].ctr <= ex_ctr_nxt;
                    if (ex_taken) begin
                        btb_q[ex_idx].target <= ex_target;
                    end
                end
            end else if (ex_taken) begin
                // Taken miss replaces whatever lives at this index; not-taken misses are ignored.
                btb_q[ex_idx].valid  <= 1'b1;
                btb_q[ex_idx].tag    <= ex_tag;
                btb_q[ex_idx].target <= ex_target;
                btb_q[ex_idx].ctr    <= ex_uncond ? CTR_ST : CTR_WT;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Purpose: directed self-checking bench for branch_target_predictor.
// Latency: checks lookup at zero latency and updates one edge after presentation.
// Backpressure: n/a.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_uncond;
    logic        ex_mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_target_predictor #(.width(32), .entries(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .predict_taken    (predict_taken),
        .predict_target   (predict_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_uncond        (ex_uncond),
        .ex_mispredict    (ex_mispredict),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one resolved control transfer for exactly one edge.
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic uncond, input logic mis);
        ex_pc         = pc;
        ex_taken      = taken;
        ex_target     = tgt;
        ex_uncond     = uncond;
        ex_mispredict = mis;
        ex_valid      = 1'b1;
        tick();
        ex_valid      = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_t,
                        input logic [31:0] exp_tgt, input logic chk_tgt);
        fetch_pc = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, predict_taken}, {31'd0, exp_t});
        if (chk_tgt) chk({tag, "_target"}, predict_target, exp_tgt);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
        ex_uncond = 1'b0; ex_mispredict = 1'b0; fetch_pc = '0;
        tick(); tick();
        rst = 1'b0;

        look("reset_0x60", 32'h60, 1'b0, 32'h0, 1'b1);
        chk("reset_bcount", branch_count, 32'd0);
        chk("reset_mcount", mispredict_count, 32'd0);

        // First taken miss allocates weakly taken.
        upd(32'h60, 1'b1, 32'h100, 1'b0, 1'b1);
        look("alloc_0x60", 32'h60, 1'b1, 32'h100, 1'b1);
        chk("alloc_bcount", branch_count, 32'd1);
        chk("alloc_mcount", mispredict_count, 32'd1);

        // Saturate at 3, then walk down: 3->2 still taken, 2->1 not taken.
        repeat (3) upd(32'h60, 1'b1, 32'h100, 1'b0, 1'b0);
        upd(32'h60, 1'b0, 32'h0, 1'b0, 1'b1);
        look("nt1_ctr2", 32'h60, 1'b1, 32'h100, 1'b1);
        upd(32'h60, 1'b0, 32'h0, 1'b0, 1'b0);
        look("nt2_ctr1", 32'h60, 1'b0, 32'h100, 1'b1);
        // Two more not-taken pin at 0; one taken gives 1 (not taken), a second gives 2.
        upd(32'h60, 1'b0, 32'h0, 1'b0, 1'b0);
        upd(32'h60, 1'b0, 32'h0, 1'b0, 1'b0);
        upd(32'h60, 1'b1, 32'h100, 1'b0, 1'b1);
        look("nowrap_ctr1", 32'h60, 1'b0, 32'h100, 1'b1);
        upd(32'h60, 1'b1, 32'h100, 1'b0, 1'b0);
        look("nowrap_ctr2", 32'h60, 1'b1, 32'h100, 1'b1);
        chk("train_bcount", branch_count, 32'd10);
        chk("train_mcount", mispredict_count, 32'd3);

        // Alias at index 8 with tag 0x11 replaces the 0x60 entry.
        upd(32'h460, 1'b1, 32'h200, 1'b0, 1'b0);
        look("alias_old", 32'h60, 1'b0, 32'h0, 1'b1);
        look("alias_new", 32'h460, 1'b1, 32'h200, 1'b1);

        // Not-taken miss never allocates.
        upd(32'h0A0, 1'b0, 32'h300, 1'b0, 1'b0);
        look("nt_miss_0xa0", 32'h0A0, 1'b0, 32'h0, 1'b1);
        look("nt_miss_keep", 32'h460, 1'b1, 32'h200, 1'b1);

        // Same-cycle lookup sees the pre-update entry.
        ex_pc = 32'h60; ex_taken = 1'b1; ex_target = 32'h500; ex_uncond = 1'b0;
        ex_mispredict = 1'b0; ex_valid = 1'b1;
        look("bypass_pre", 32'h60, 1'b0, 32'h0, 1'b1);
        tick();
        ex_valid = 1'b0;
        look("bypass_post", 32'h60, 1'b1, 32'h500, 1'b1);
        look("bypass_evict", 32'h460, 1'b0, 32'h0, 1'b1);

        // Unconditional miss allocates strongly taken: one not-taken keeps it taken.
        upd(32'h80, 1'b1, 32'h40, 1'b1, 1'b0);
        look("jal_alloc", 32'h80, 1'b1, 32'h40, 1'b1);
        upd(32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
        look("jal_nt1", 32'h80, 1'b1, 32'h40, 1'b1);
        upd(32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
        look("jal_nt2", 32'h80, 1'b0, 32'h40, 1'b1);

        // Unconditional hit forces ctr=3 and new target; conditional taken hit rewrites target.
        upd(32'h60, 1'b1, 32'h600, 1'b1, 1'b0);
        upd(32'h60, 1'b0, 32'h0, 1'b0, 1'b0);
        look("jal_hit_nt1", 32'h60, 1'b1, 32'h600, 1'b1);
        upd(32'h60, 1'b0, 32'h0, 1'b0, 1'b0);
        look("jal_hit_nt2", 32'h60, 1'b0, 32'h600, 1'b1);
        upd(32'h60, 1'b1, 32'h700, 1'b0, 1'b1);
        look("hit_retarget", 32'h60, 1'b1, 32'h700, 1'b1);
        chk("final_bcount", branch_count, 32'd20);
        chk("final_mcount", mispredict_count, 32'd4);

        // Update coincident with reset is dropped; everything misses afterwards.
        rst = 1'b1;
        ex_pc = 32'hC0; ex_taken = 1'b1; ex_target = 32'h44; ex_uncond = 1'b1;
        ex_mispredict = 1'b1; ex_valid = 1'b1;
        tick();
        rst = 1'b0; ex_valid = 1'b0;
        look("rst_upd_0xc0", 32'hC0, 1'b0, 32'h0, 1'b1);
        look("rst_0x80", 32'h80, 1'b0, 32'h0, 1'b1);
        look("rst_0x60", 32'h60, 1'b0, 32'h0, 1'b1);
        chk("rst_bcount", branch_count, 32'd0);
        chk("rst_mcount", mispredict_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
